// File: rtl/lcd_fill_writer.sv
// Producer for the 17-bit {RS, DATA} LCD command FIFO: optional panel init, then rectangle fills.
// Define INIT_SEQ_EN to emit the Sleep Out / pixel format / MADCTL / Display On sequence after reset.
module lcd_fill_writer #(
    parameter int         WIDTH        = 240,
    parameter int         HEIGHT       = 320,
    parameter int         DELAY_CYCLES = 6000000,
    parameter logic [7:0] MADCTL_VAL   = 8'h48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_x0,
    input  logic [8:0]  req_y0,
    input  logic [8:0]  req_x1,
    input  logic [8:0]  req_y1,
    input  logic [15:0] req_color,
    output logic        req_err,
    output logic        init_done,
    output logic        busy,
    input  logic        wfull,
    output logic        winc,
    output logic [16:0] wdata
);

    typedef enum logic [3:0] {
        INIT_CMD, INIT_DLY, IDLE, CASET, CA_P, PASET, PA_P, RAMWR, PIXEL
    } state_t;

    localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
    localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);
    localparam int         DW       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

`ifdef INIT_SEQ_EN
    localparam state_t RST_STATE = INIT_CMD;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t      state;
    logic [16:0] pend;
    logic        pend_v;
    logic [1:0]  pidx;
    logic [16:0] cnt;
    logic [8:0]  x0_q, y0_q, x1_q, y1_q;
    logic [15:0] color_q;
    logic        init_done_q;
    logic        req_err_q;
    logic        accept;
    logic        req_ok;
    logic [8:0]  span_x, span_y;

`ifdef INIT_SEQ_EN
    logic [2:0]    iidx;
    logic [DW-1:0] dly;
`endif

    function automatic logic [16:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    init_word = {1'b0, 16'h0011};
            3'd1:    init_word = {1'b0, 16'h003A};
            3'd2:    init_word = {1'b1, 16'h0055};
            3'd3:    init_word = {1'b0, 16'h0036};
            3'd4:    init_word = {1'b1, 8'h00, MADCTL_VAL};
            3'd5:    init_word = {1'b0, 16'h0029};
            default: init_word = '0;
        endcase
    endfunction

    // Four address parameters: start hi, start lo, end hi, end lo.
    function automatic logic [16:0] coord_word(input logic [1:0] idx,
                                               input logic [8:0] a, input logic [8:0] b);
        case (idx)
            2'd0:    coord_word = {1'b1, 15'b0, a[8]};
            2'd1:    coord_word = {1'b1, 8'h00, a[7:0]};
            2'd2:    coord_word = {1'b1, 15'b0, b[8]};
            default: coord_word = {1'b1, 8'h00, b[7:0]};
        endcase
    endfunction

    assign winc      = pend_v & ~wfull;
    assign wdata     = pend;
    assign req_ready = (state == IDLE) & init_done_q;
    assign accept    = req_valid & req_ready;
    assign req_ok    = (req_x0 <= req_x1) && (req_y0 <= req_y1) &&
                       ({1'b0, req_x1} < WIDTH_L) && ({1'b0, req_y1} < HEIGHT_L);
    assign req_err   = req_err_q;
    assign init_done = init_done_q;
    assign busy      = (state inside {CASET, CA_P, PASET, PA_P, RAMWR, PIXEL}) | (accept & req_ok);
    assign span_x    = x1_q - x0_q + 9'd1;
    assign span_y    = y1_q - y0_q + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST_STATE;
            pend        <= '0;
            pend_v      <= 1'b0;
            pidx        <= '0;
            cnt         <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            init_done_q <= 1'b0;
            req_err_q   <= 1'b0;
`ifdef INIT_SEQ_EN
            iidx        <= '0;
            dly         <= '0;
`endif
        end else begin
            req_err_q <= 1'b0;
`ifndef INIT_SEQ_EN
            init_done_q <= 1'b1;
`endif
            case (state)
`ifdef INIT_SEQ_EN
                INIT_CMD: begin
                    if (!pend_v) begin
                        pend   <= init_word(iidx);
                        pend_v <= 1'b1;
                    end else if (winc) begin
                        if (iidx == 3'd0) begin
                            pend_v <= 1'b0;
                            dly    <= DW'(DELAY_CYCLES - 1);
                            state  <= INIT_DLY;
                        end else if (iidx == 3'd5) begin
                            pend_v      <= 1'b0;
                            init_done_q <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            iidx <= iidx + 3'd1;
                            pend <= init_word(iidx + 3'd1);
                        end
                    end
                end
                // Next word is preloaded on the last wait cycle so the gap is exactly DELAY_CYCLES.
                INIT_DLY: begin
                    if (dly == '0) begin
                        iidx   <= 3'd1;
                        pend   <= init_word(3'd1);
                        pend_v <= 1'b1;
                        state  <= INIT_CMD;
                    end else begin
                        dly <= dly - 1'b1;
                    end
                end
`endif
                IDLE: begin
                    if (accept) begin
                        x0_q    <= req_x0;
                        y0_q    <= req_y0;
                        x1_q    <= req_x1;
                        y1_q    <= req_y1;
                        color_q <= req_color;
                        if (req_ok) begin
                            pend   <= {1'b0, 16'h002A};
                            pend_v <= 1'b1;
                            state  <= CASET;
                        end else begin
                            req_err_q <= 1'b1;
                        end
                    end
                end
                CASET: if (winc) begin
                    pend  <= coord_word(2'd0, x0_q, x1_q);
                    pidx  <= '0;
                    state <= CA_P;
                end
                CA_P: if (winc) begin
                    pidx <= pidx + 2'd1;
                    if (pidx == 2'd3) begin
                        pend  <= {1'b0, 16'h002B};
                        state <= PASET;
                    end else begin
                        pend <= coord_word(pidx + 2'd1, x0_q, x1_q);
                    end
                end
                PASET: if (winc) begin
                    pend  <= coord_word(2'd0, y0_q, y1_q);
                    pidx  <= '0;
                    state <= PA_P;
                end
                PA_P: if (winc) begin
                    pidx <= pidx + 2'd1;
                    if (pidx == 2'd3) begin
                        pend  <= {1'b0, 16'h002C};
                        state <= RAMWR;
                    end else begin
                        pend <= coord_word(pidx + 2'd1, y0_q, y1_q);
                    end
                end
                RAMWR: if (winc) begin
                    pend  <= {1'b1, color_q};
                    cnt   <= {8'b0, span_x} * {8'b0, span_y};
                    state <= PIXEL;
                end
                PIXEL: if (winc) begin
                    if (cnt == 17'd1) begin
                        pend_v <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_fill_writer.sv
// Directed bench for lcd_fill_writer: init sequence, fill vectors, back-pressure and mid-fill reset.
module tb_lcd_fill_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
    logic [15:0] req_color = '0;
    logic        req_err, init_done, busy;
    logic        wfull = 1'b0;
    logic        winc;
    logic [16:0] wdata;

    lcd_fill_writer #(
        .WIDTH(240), .HEIGHT(320), .DELAY_CYCLES(10), .MADCTL_VAL(8'h48)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_color(req_color), .req_err(req_err),
        .init_done(init_done), .busy(busy),
        .wfull(wfull), .winc(winc), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  x0, y0, x1, y1;
        logic [15:0] color;
        logic        err;
        int          n;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic [16:0] words[$];
    int unsigned wcyc[$];
    logic [16:0] exp_q[$];
    logic        chk_hold = 1'b0;
    logic        prev_full = 1'b0;
    logic [16:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && winc) begin
            words.push_back(wdata);
            wcyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // While the FIFO reports full the pending word must not move.
    always @(negedge clk) begin
        if (chk_hold) begin
            if (prev_full) check("hold_stable", 32'(wdata), 32'(prev_data));
            prev_full = wfull;
            prev_data = wdata;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic void build_exp(input vec_t v);
        exp_q.delete();
        exp_q.push_back({1'b0, 16'h002A});
        exp_q.push_back({1'b1, 15'b0, v.x0[8]});
        exp_q.push_back({1'b1, 8'h00, v.x0[7:0]});
        exp_q.push_back({1'b1, 15'b0, v.x1[8]});
        exp_q.push_back({1'b1, 8'h00, v.x1[7:0]});
        exp_q.push_back({1'b0, 16'h002B});
        exp_q.push_back({1'b1, 15'b0, v.y0[8]});
        exp_q.push_back({1'b1, 8'h00, v.y0[7:0]});
        exp_q.push_back({1'b1, 15'b0, v.y1[8]});
        exp_q.push_back({1'b1, 8'h00, v.y1[7:0]});
        exp_q.push_back({1'b0, 16'h002C});
        for (int i = 0; i < v.n; i++) exp_q.push_back({1'b1, v.color});
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_winc"}, 32'(winc), 0);
        check({tag, "_wdata"}, 32'(wdata), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_req_err"}, 32'(req_err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_init_done"}, 32'(init_done), 0);
    endtask

    task automatic post_reset();
`ifdef INIT_SEQ_EN
        logic [16:0] init_exp [6];
        init_exp = '{17'h00011, 17'h0003A, 17'h10055, 17'h00036, 17'h10048, 17'h00029};
        words.delete();
        wcyc.delete();
        for (int i = 0; i < 100 && words.size() < 6; i++) begin
            step();
            if (words.size() < 6) check("init_done_early", 32'(init_done), 0);
        end
        check("init_count", 32'(words.size()), 6);
        if (words.size() == 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("init_word%0d", i), 32'(words[i]), 32'(init_exp[i]));
            check("init_gap", wcyc[1] - wcyc[0], 11);
        end
        check("init_done_at_last", 32'(init_done), 0);
        step();
        check("init_done_after", 32'(init_done), 1);
        check("init_ready", 32'(req_ready), 1);
`else
        step();
        check("init_done_noinit", 32'(init_done), 1);
        check("ready_noinit", 32'(req_ready), 1);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        wfull = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        post_reset();
    endtask

    task automatic send_req(input vec_t v);
        for (int i = 0; i < 200 && !req_ready; i++) step();
        check("ready_before_req", 32'(req_ready), 1);
        req_x0 = v.x0; req_y0 = v.y0; req_x1 = v.x1; req_y1 = v.y1;
        req_color = v.color;
        req_valid = 1'b1;
        #1;
        check("busy_accept", 32'(busy), 32'(!v.err));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_fill(input vec_t v, input bit nostall, output int base);
        int last;
        build_exp(v);
        base = words.size();
        send_req(v);
        step();
        check("req_err", 32'(req_err), 32'(v.err));
        if (v.err) begin
            repeat (4) step();
            check("err_no_words", 32'(words.size()), 32'(base));
            check("err_ready", 32'(req_ready), 1);
            check("err_pulse_clear", 32'(req_err), 0);
        end else begin
            for (int i = 0; i < 2000 && words.size() < base + exp_q.size(); i++) step();
            check("busy_last", 32'(busy), 1);
            check("ready_last", 32'(req_ready), 0);
            step();
            check("busy_after", 32'(busy), 0);
            check("ready_after", 32'(req_ready), 1);
            check("fill_count", 32'(words.size() - base), 32'(exp_q.size()));
            if (words.size() - base == exp_q.size()) begin
                for (int i = 0; i < exp_q.size(); i++)
                    check($sformatf("fill_word%0d", i), 32'(words[base + i]), 32'(exp_q[i]));
                last = base + exp_q.size() - 1;
                if (nostall) check("fill_back_to_back", wcyc[last] - wcyc[base], 32'(exp_q.size() - 1));
            end
        end
    endtask

    vec_t vecs [9];
    logic [16:0] lit0 [15];
    logic [16:0] lit1 [8];

    initial begin
        int base, hsz, hold_n;
        bit held;
        vec_t v;

        vecs[0] = '{9'd0,   9'd0,   9'd1,   9'd1,   16'hF800, 1'b0, 4};
        vecs[1] = '{9'd239, 9'd319, 9'd239, 9'd319, 16'h07E0, 1'b0, 1};
        vecs[2] = '{9'd5,   9'd0,   9'd4,   9'd0,   16'h1234, 1'b1, 0};
        vecs[3] = '{9'd0,   9'd0,   9'd0,   9'd320, 16'h1234, 1'b1, 0};
        vecs[4] = '{9'd10,  9'd20,  9'd12,  9'd25,  16'hABCD, 1'b0, 18};
        vecs[5] = '{9'd0,   9'd0,   9'd239, 9'd0,   16'hFFFF, 1'b0, 240};
        vecs[6] = '{9'd0,   9'd5,   9'd3,   9'd4,   16'h0001, 1'b1, 0};
        vecs[7] = '{9'd0,   9'd0,   9'd240, 9'd0,   16'h0002, 1'b1, 0};
        vecs[8] = '{9'd100, 9'd300, 9'd103, 9'd319, 16'h5A5A, 1'b0, 80};

        lit0 = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000, 17'h10001,
                 17'h0002B, 17'h10000, 17'h10000, 17'h10000, 17'h10001,
                 17'h0002C, 17'h1F800, 17'h1F800, 17'h1F800, 17'h1F800};
        lit1 = '{17'h10000, 17'h100EF, 17'h10000, 17'h100EF,
                 17'h10001, 17'h1003F, 17'h10001, 17'h1003F};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            do_fill(vecs[i], 1'b1, base);
            if (i == 0 && words.size() == base + 15)
                for (int k = 0; k < 15; k++) check($sformatf("lit0_w%0d", k), 32'(words[base + k]), 32'(lit0[k]));
            if (i == 1 && words.size() == base + 12) begin
                for (int k = 0; k < 4; k++) check($sformatf("lit1_ca%0d", k), 32'(words[base + 1 + k]), 32'(lit1[k]));
                for (int k = 0; k < 4; k++) check($sformatf("lit1_pa%0d", k), 32'(words[base + 6 + k]), 32'(lit1[4 + k]));
            end
        end

        // Back-pressure: toggling full plus a 20-cycle stall inside the pixel run.
        v = '{9'd0, 9'd0, 9'd3, 9'd0, 16'h1F2E, 1'b0, 4};
        build_exp(v);
        base = words.size();
        send_req(v);
        prev_full = 1'b0;
        chk_hold = 1'b1;
        held = 1'b0;
        hold_n = 0;
        hsz = 0;
        for (int i = 0; i < 400 && words.size() < base + 15; i++) begin
            if (hold_n > 0) begin
                wfull = 1'b1;
                hold_n--;
                if (hold_n == 0) check("stall_no_words", 32'(words.size()), 32'(hsz));
            end else if (!held && words.size() >= base + 12) begin
                held = 1'b1;
                wfull = 1'b1;
                hold_n = 19;
                hsz = words.size();
            end else begin
                wfull = ~wfull;
            end
            @(posedge clk);
            #1;
        end
        wfull = 1'b0;
        step();
        chk_hold = 1'b0;
        check("bp_stall_seen", 32'(held), 1);
        check("bp_busy_after", 32'(busy), 0);
        check("bp_ready_after", 32'(req_ready), 1);
        check("bp_count", 32'(words.size() - base), 15);
        if (words.size() - base == 15)
            for (int k = 0; k < 15; k++) check($sformatf("bp_word%0d", k), 32'(words[base + k]), 32'(exp_q[k]));

        // Reset in the middle of a 100-pixel fill.
        v = '{9'd0, 9'd0, 9'd9, 9'd9, 16'h4321, 1'b0, 100};
        base = words.size();
        send_req(v);
        for (int i = 0; i < 200 && words.size() < base + 40; i++) step();
        check("midfill_progress", 32'(words.size() >= base + 40), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        hsz = words.size();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset();
`ifndef INIT_SEQ_EN
        repeat (10) step();
        check("no_resume", 32'(words.size()), 32'(hsz));
`endif
        do_fill(vecs[0], 1'b1, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/lcd_fill_writer.md
Name: lcd_fill_writer

Overview:
Producer side of the 17-bit LCD command FIFO feeding the ILI9341 8080-bus write interface. Each FIFO word is {RS, DATA[15:0]}: RS=0 is a command byte and RS=1 is a parameter or pixel.
- After reset, optionally emits the panel init sequence.
- Then accepts rectangle-fill requests and expands each into CASET/PASET/RAMWR plus N pixel words.
Sits between the game renderer (request side) and the FIFO write port.

Parameters:
WIDTH, 240, panel columns; x1 must be < WIDTH
HEIGHT, 320, panel rows; y1 must be < HEIGHT
DELAY_CYCLES, 6000000, clk cycles to wait after Sleep Out (120 ms at 50 MHz); minimum 1
MADCTL_VAL, 8'h48, Memory Access Control parameter byte

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  fill request valid
req_ready  output  1  block can accept a request this cycle
req_x0  input  9  left column, inclusive
req_y0  input  9  top row, inclusive
req_x1  input  9  right column, inclusive
req_y1  input  9  bottom row, inclusive
req_color  input  16  RGB565 fill colour
req_err  output  1  one-cycle pulse: request rejected
init_done  output  1  high once the init sequence has fully entered the FIFO
busy  output  1  high while a fill is being emitted
wfull  input  1  FIFO full
winc  output  1  FIFO write strobe
wdata  output  17  FIFO write word {RS, DATA}

Behaviour:
- Reset (asynchronous, any time, including mid-fill):
  - winc=0, wdata=0, req_ready=0, req_err=0, busy=0, init_done=0.
  - Counters are cleared and the FSM goes to INIT (or IDLE without INIT_SEQ_EN).
  - A partially emitted fill is abandoned; nothing resumes after reset.
- FIFO handshake:
  - The word to be written is held in a register `pend`, flagged by `pend_v`.
  - winc = pend_v & ~wfull (combinational in wfull); wdata = pend.
  - A word is consumed only on a cycle with winc=1; the FSM then loads the next word.
  - Maximum rate is one word per clk.
  - While wfull=1, pend/wdata are held stable indefinitely; no word is dropped or duplicated.
- Request handshake:
  - req_ready = (state==IDLE) & init_done.
  - A request is accepted when req_valid & req_ready; req_* fields are latched that cycle.
- Validity check on accept:
  - A request is invalid if x0>x1, y0>y1, x1>=WIDTH or y1>=HEIGHT.
  - Invalid: req_err=1 the next cycle, nothing is emitted, FSM stays in IDLE.
- Valid fill word sequence (11+N words in order):
  - 0_002A, 1_{7'b0,x0[8]}, 1_x0[7:0], 1_{7'b0,x1[8]}, 1_x1[7:0]
  - 0_002B, then the same four parameter words for y0 and y1
  - 0_002C
  - then N words of 1_color, where N=(x1-x0+1)*(y1-y0+1)
  - N uses a 17-bit counter (max 76800); a single-pixel fill gives N=1.
  - Parameter words carry the high byte as 8'h00/8'h01 in DATA[7:0], with DATA[15:8]=0.
- FSM states: INIT_CMD, INIT_DLY, IDLE, CASET, CA_P, PASET, PA_P, RAMWR, PIXEL.
  - CA_P and PA_P index their four parameters with a 2-bit counter.
  - PIXEL decrements the count on each winc; on the winc of the last pixel it goes to IDLE.
  - req_ready=1 on the following cycle.
- busy=1 from the accept cycle until the last pixel's winc cycle, inclusive.
- A request presented while busy is not accepted (req_ready=0); the requester holds it.

Optional Feature:
Macro INIT_SEQ_EN.
- Defined, after reset, emits in order:
  - 0_0011 (Sleep Out)
  - then waits DELAY_CYCLES counted from that word's winc; winc=0 during the wait
  - then 0_003A, 1_0055 (16 bpp)
  - then 0_0036, 1_{8'h00,MADCTL_VAL}
  - then 0_0029 (Display On)
  - init_done rises the cycle after the 0_0029 winc.
- Not defined: INIT_CMD/INIT_DLY are absent; init_done=1 from the first clk after reset release, and the FSM starts in IDLE.

Test Plan:
INIT_SEQ_EN, DELAY_CYCLES=10, wfull=0 -> words 0_0011, gap of exactly 10 cycles, then 0_003A, 1_0055, 0_0036, 1_0048, 0_0029; init_done high the cycle after the last word.
Fill (0,0)-(1,1) colour F800, wfull=0 -> 15 consecutive winc: 0_002A, 1_0000, 1_0000, 1_0000, 1_0001, 0_002B, 1_0000, 1_0000, 1_0000, 1_0001, 0_002C, then 4x 1_F800; busy drops after the 15th.
Fill (239,319)-(239,319) -> CASET params 0000, 00EF, 0000, 00EF; PASET params 0001, 003F, 0001, 003F; exactly 1 pixel word.
Request x0=5, x1=4, then a separate request y1=320 -> each gets a req_err pulse, zero winc, req_ready back high.
Fill (0,0)-(3,0) with wfull toggled 1 every other cycle and held high 20 cycles mid-pixel -> 15 words total, no duplicates or drops, wdata stable while wfull=1.
Assert rst_n low during PIXEL of a 100-pixel fill -> winc=0 immediately, all outputs at reset values; after release the init (or IDLE) behaviour restarts cleanly.
